// File: rtl/icap_stream_feeder.sv
// icap_stream_feeder: pops wide FIFO words and serialises each one into
// DATA_SIZE/ICAP_DATA_SIZE ICAP writes, with busy back-pressure, abort,
// back-to-back beat prefetch and a running count of words written.
// Build option: define ICAP_BITSWAP_EN to bit-reverse every byte of icap_data
// (Xilinx ICAP bit ordering); control and timing are unaffected.
module icap_stream_feeder #(
  parameter int DATA_SIZE      = 256,
  parameter int ICAP_DATA_SIZE = 32,
  parameter int FLAG_SIZE      = 1,
  parameter int LSW_FIRST      = 1,
  parameter int COUNT_WIDTH    = 32
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [FLAG_SIZE-1:0]      fifo_empty,
  input  logic [DATA_SIZE-1:0]      fifo_data,
  output logic [FLAG_SIZE-1:0]      fifo_read_en,
  input  logic                      icap_busy,
  output logic [ICAP_DATA_SIZE-1:0] icap_data,
  output logic [FLAG_SIZE-1:0]      icap_en,
  input  logic                      enable,
  input  logic                      abort,
  input  logic                      clear_count,
  output logic [COUNT_WIDTH-1:0]    words_sent,
  output logic [1:0]                state,
  output logic                      idle
);

  localparam int N = DATA_SIZE / ICAP_DATA_SIZE;
  localparam int IDX_W = $clog2(N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_WAIT  = 2'b01,
    S_SHIFT = 2'b10
  } state_t;

  state_t                      state_q, state_d;
  logic [DATA_SIZE-1:0]        shift_q;
  logic [IDX_W-1:0]            idx_q;
  logic [IDX_W-1:0]            sel;
  logic [ICAP_DATA_SIZE-1:0]   slice_raw;
  logic [COUNT_WIDTH-1:0]      count_q;
  logic                        rd;
  logic                        wr;
  logic                        has_data;
  logic                        last_slice;

  // Reverse the bit order inside each byte, keeping byte positions.
  function automatic logic [ICAP_DATA_SIZE-1:0] byte_bitswap(
    input logic [ICAP_DATA_SIZE-1:0] w
  );
    logic [ICAP_DATA_SIZE-1:0] r;
    r = '0;
    for (int b = 0; b < ICAP_DATA_SIZE / 8; b++) begin
      for (int i = 0; i < 8; i++) begin
        r[b*8 + i] = w[b*8 + 7 - i];
      end
    end
    return r;
  endfunction

  assign has_data   = ~|fifo_empty;
  assign last_slice = (idx_q == LAST_IDX);

  // Next-state and strobe decode; abort overrides every other transition.
  always_comb begin
    state_d = state_q;
    rd      = 1'b0;
    wr      = 1'b0;
    case (state_q)
      S_WAIT: begin
        state_d = abort ? S_IDLE : S_SHIFT;
      end
      S_SHIFT: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (!icap_busy) begin
          wr = 1'b1;
          if (last_slice) begin
            // Prefetch the next beat so only the WAIT cycle is a bubble.
            if (enable && has_data) begin
              rd      = 1'b1;
              state_d = S_WAIT;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
      end
      default: begin
        rd      = enable && has_data && !abort;
        state_d = rd ? S_WAIT : S_IDLE;
      end
    endcase
  end

  // State, beat capture and slice index; index parks on the last slice so
  // icap_data keeps its final value between beats.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_WAIT && !abort) begin
        shift_q <= fifo_data;
        idx_q   <= '0;
      end else if (wr && !last_slice) begin
        idx_q <= idx_q + 1'b1;
      end
    end
  end

  // Running write count; a clear coinciding with a write leaves 1.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (clear_count) begin
      count_q <= wr ? COUNT_WIDTH'(1) : '0;
    end else if (wr) begin
      count_q <= count_q + 1'b1;
    end
  end

  // Slice selection in the configured word order.
  always_comb begin
    sel       = (LSW_FIRST != 0) ? idx_q : (LAST_IDX - idx_q);
    slice_raw = shift_q[sel*ICAP_DATA_SIZE +: ICAP_DATA_SIZE];
  end

`ifdef ICAP_BITSWAP_EN
  assign icap_data = byte_bitswap(slice_raw);
`else
  assign icap_data = slice_raw;
`endif

  // Strobes are forced low while reset is asserted.
  assign fifo_read_en = {FLAG_SIZE{rd & ~reset}};
  assign icap_en      = {FLAG_SIZE{wr & ~reset}};
  assign words_sent   = count_q;
  assign state        = state_q;
  assign idle         = !(state_q == S_WAIT || state_q == S_SHIFT);

endmodule

// File: tb/tb_icap_stream_feeder.sv
// Bench for icap_stream_feeder: directed beat/order/back-pressure/abort/reset
// sequences plus randomized traffic against a slice-queue reference model.
// Two instances share the stimulus: one sends LSW first, the other MSW first.
module tb_icap_stream_feeder;

  localparam int DW = 256;
  localparam int IW = 32;
  localparam int N  = DW / IW;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [0:0]    fifo_empty;
  logic [DW-1:0] fifo_data;
  logic [0:0]    rd0, rd1, en0, en1;
  logic          icap_busy = 1'b0;
  logic          enable = 1'b0;
  logic          abort = 1'b0;
  logic          clear_count = 1'b0;
  logic [IW-1:0] d0, d1;
  logic [31:0]   ws0, ws1;
  logic [1:0]    st0, st1;
  logic          idle0, idle1;

  int checks = 0;
  int errors = 0;

  // FIFO model: standard read, data valid the cycle after the pop strobe.
  logic [DW-1:0] mem [0:4095];
  int wr_ptr = 0;
  int rd_ptr = 0;

  assign fifo_empty = (rd_ptr == wr_ptr) ? 1'b1 : 1'b0;

  always @(posedge clock) begin
    if (reset) begin
      rd_ptr    <= wr_ptr;
      fifo_data <= '0;
    end else if (rd0[0]) begin
      fifo_data <= mem[rd_ptr];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  always #5 clock = ~clock;

  icap_stream_feeder #(.DATA_SIZE(DW), .ICAP_DATA_SIZE(IW), .FLAG_SIZE(1),
                       .LSW_FIRST(1), .COUNT_WIDTH(32)) dut_lsw (
    .clock(clock), .reset(reset), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_read_en(rd0), .icap_busy(icap_busy), .icap_data(d0), .icap_en(en0),
    .enable(enable), .abort(abort), .clear_count(clear_count),
    .words_sent(ws0), .state(st0), .idle(idle0));

  icap_stream_feeder #(.DATA_SIZE(DW), .ICAP_DATA_SIZE(IW), .FLAG_SIZE(1),
                       .LSW_FIRST(0), .COUNT_WIDTH(32)) dut_msw (
    .clock(clock), .reset(reset), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_read_en(rd1), .icap_busy(icap_busy), .icap_data(d1), .icap_en(en1),
    .enable(enable), .abort(abort), .clear_count(clear_count),
    .words_sent(ws1), .state(st1), .idle(idle1));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk_word(input int base);
    logic [DW-1:0] w;
    for (int i = 0; i < N; i++) w[i*IW +: IW] = 32'hffff0000 + 32'(base + i);
    return w;
  endfunction

  // Expected ICAP word number i of a beat for the given order.
  function automatic logic [IW-1:0] exp_slice(input logic [DW-1:0] w, input int i, input bit lsw);
    int k;
    logic [IW-1:0] s;
    logic [IW-1:0] r;
    k = lsw ? i : (N - 1 - i);
    s = w[k*IW +: IW];
    r = s;
`ifdef ICAP_BITSWAP_EN
    for (int b = 0; b < IW / 8; b++)
      for (int j = 0; j < 8; j++) r[b*8 + j] = s[b*8 + 7 - j];
`endif
    return r;
  endfunction

  task automatic push(input logic [DW-1:0] w);
    mem[wr_ptr] = w;
    wr_ptr++;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic reset_dut();
    reset = 1'b1; enable = 1'b0; abort = 1'b0; icap_busy = 1'b0; clear_count = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  // Reference model: queues of slices still owed, and the expected count.
  logic [IW-1:0] exp_l[$];
  logic [IW-1:0] exp_m[$];
  int cnt = 0;

  task automatic model_step();
    logic [DW-1:0] w;
    check("words_sent_lsw", ws0, cnt);
    check("words_sent_msw", ws1, cnt);
    check("rd_while_empty", rd0 & fifo_empty, 0);
    check("rd_match", rd1, rd0);
    check("en_match", en1, en0);
    if (en0[0]) begin
      check("en_while_blocked", icap_busy | abort, 0);
      if (exp_l.size() == 0) begin
        check("en_unexpected", 1, 0);
      end else begin
        check("stream_lsw", d0, exp_l.pop_front());
        check("stream_msw", d1, exp_m.pop_front());
      end
    end else if (st0 == 2'b10 && exp_l.size() != 0) begin
      check("hold_lsw", d0, exp_l[0]);
      check("hold_msw", d1, exp_m[0]);
    end
    if (clear_count) cnt = en0[0] ? 1 : 0;
    else if (en0[0]) cnt++;
    if (rd0[0]) begin
      w = mem[rd_ptr];
      for (int i = 0; i < N; i++) begin
        exp_l.push_back(exp_slice(w, i, 1'b1));
        exp_m.push_back(exp_slice(w, i, 1'b0));
      end
    end
    if (abort) begin
      exp_l.delete();
      exp_m.delete();
    end
  endtask

  typedef struct {
    logic       rd;
    logic       en;
    logic [1:0] st;
    int         slice;
  } vec_t;

  vec_t tbl[11];

  initial begin
    logic [DW-1:0] w1, w2, rw;
    int c;
    bit drained;
    w1 = mk_word(1);
    w2 = mk_word('h11);

    tbl[0] = '{1'b1, 1'b0, 2'b00, -1};
    tbl[1] = '{1'b0, 1'b0, 2'b01, -1};
    for (int i = 0; i < N; i++) tbl[2 + i] = '{1'b0, 1'b1, 2'b10, i};
    tbl[10] = '{1'b0, 1'b0, 2'b00, -1};

    // Reset state, with a word waiting and enable high.
    reset = 1'b1;
    push(w1);
    enable = 1'b1;
    #2;
    check("rst_state", st0, 2'b00);
    check("rst_idle", idle0, 1'b1);
    check("rst_rd", rd0, 1'b0);
    check("rst_en", en0, 1'b0);
    check("rst_data", d0, 32'h0);
    check("rst_count", ws0, 32'h0);

    // Basic beat, table driven, both word orders.
    reset_dut();
    push(w1);
    enable = 1'b1;
    for (int k = 0; k < 11; k++) begin
      @(negedge clock);
      check($sformatf("basic_rd_c%0d", k), rd0, tbl[k].rd);
      check($sformatf("basic_rd_msw_c%0d", k), rd1, tbl[k].rd);
      check($sformatf("basic_en_c%0d", k), en0, tbl[k].en);
      check($sformatf("basic_en_msw_c%0d", k), en1, tbl[k].en);
      check($sformatf("basic_state_c%0d", k), st0, tbl[k].st);
      if (tbl[k].slice >= 0) begin
        check($sformatf("basic_data_c%0d", k), d0, exp_slice(w1, tbl[k].slice, 1'b1));
        check($sformatf("order_data_c%0d", k), d1, exp_slice(w1, tbl[k].slice, 1'b0));
      end
`ifdef ICAP_BITSWAP_EN
      if (k == 2) check("bitswap_w0", d0, 32'hffff0080);
      if (k == 3) check("bitswap_w1", d0, 32'hffff0040);
`else
      if (k == 2) check("raw_w0", d0, 32'hffff0001);
      if (k == 2) check("raw_msw_w0", d1, 32'hffff0008);
`endif
      tick();
    end
    @(negedge clock);
    check("basic_count", ws0, 8);
    check("basic_count_msw", ws1, 8);
    check("basic_idle", idle0, 1'b1);

    // Back-pressure on the third slice for three cycles.
    reset_dut();
    push(w1);
    enable = 1'b1;
    for (int k = 0; k < 13; k++) begin
      icap_busy = (k >= 4 && k <= 6);
      @(negedge clock);
      check($sformatf("bp_en_c%0d", k), en0, (k >= 2 && !(k >= 4 && k <= 6)));
      if (k >= 2) begin
        c = (k < 4) ? k - 2 : (k <= 6) ? 2 : k - 5;
        check($sformatf("bp_data_c%0d", k), d0, exp_slice(w1, c, 1'b1));
      end
      tick();
    end
    icap_busy = 1'b0;
    @(negedge clock);
    check("bp_count", ws0, 8);
    check("bp_state", st0, 2'b00);

    // Back-to-back beats.
    reset_dut();
    push(w1);
    push(w2);
    enable = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      check($sformatf("b2b_rd_c%0d", k), rd0, (k == 0 || k == 9));
      check($sformatf("b2b_en_c%0d", k), en0, ((k >= 2 && k <= 9) || (k >= 11 && k <= 18)));
      if (k >= 2 && k <= 9) check($sformatf("b2b_data_c%0d", k), d0, exp_slice(w1, k - 2, 1'b1));
      if (k >= 11 && k <= 18) check($sformatf("b2b_data_c%0d", k), d0, exp_slice(w2, k - 11, 1'b1));
      tick();
    end
    @(negedge clock);
    check("b2b_count", ws0, 16);

    // Abort on the fifth slice.
    reset_dut();
    push(w1);
    enable = 1'b1;
    for (int k = 0; k < 8; k++) begin
      abort = (k == 6);
      @(negedge clock);
      if (k >= 2 && k <= 5) check($sformatf("abort_en_c%0d", k), en0, 1'b1);
      if (k == 6) begin
        check("abort_no_en", en0, 1'b0);
        check("abort_no_rd", rd0, 1'b0);
      end
      if (k == 7) check("abort_state", st0, 2'b00);
      tick();
    end
    abort = 1'b0;
    @(negedge clock);
    check("abort_count", ws0, 4);

    // Reset in the middle of a beat.
    reset_dut();
    push(w1);
    enable = 1'b1;
    repeat (7) tick();
    @(negedge clock);
    check("pre_reset_en", en0, 1'b1);
    @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    check("mid_rst_state", st0, 2'b00);
    check("mid_rst_en", en0, 1'b0);
    check("mid_rst_rd", rd0, 1'b0);
    check("mid_rst_data", d0, 32'h0);
    check("mid_rst_data_msw", d1, 32'h0);
    check("mid_rst_count", ws0, 32'h0);
    check("mid_rst_idle", idle0, 1'b1);

    // Randomized traffic against the slice-queue model.
    reset_dut();
    exp_l.delete();
    exp_m.delete();
    cnt = 0;
    for (int k = 0; k < 3000; k++) begin
      icap_busy   = ($urandom_range(0, 9) < 3);
      enable      = ($urandom_range(0, 9) < 8);
      abort       = ($urandom_range(0, 49) == 0);
      clear_count = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 3) == 0 && (wr_ptr - rd_ptr) < 8) begin
        for (int i = 0; i < DW / 32; i++) rw[i*32 +: 32] = $urandom;
        push(rw);
      end
      @(negedge clock);
      model_step();
      tick();
    end

    // Drain: everything queued must come out.
    icap_busy = 1'b0; enable = 1'b1; abort = 1'b0; clear_count = 1'b0;
    drained = 1'b0;
    for (int k = 0; k < 500 && !drained; k++) begin
      @(negedge clock);
      model_step();
      if (fifo_empty[0] && exp_l.size() == 0 && idle0 && !rd0[0]) drained = 1'b1;
      tick();
    end
    check("drain_complete", drained, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

endmodule

// File: doc/icap_stream_feeder.md
Name: icap_stream_feeder

Overview:
- Parametrised successor to the ICAP state machine.
- Pops wide words from a standard (non-FWFT) FIFO and serialises each into DATA_SIZE/ICAP_DATA_SIZE ICAP words.
- Adds selectable word order, ICAP busy back-pressure, enable/abort control, back-to-back beat prefetch and a running sent-word counter.
- Sits between the bitstream-buffer FIFO and the ICAP primitive wrapper.

Parameters:
DATA_SIZE, 256, FIFO word width; must be an integer multiple of ICAP_DATA_SIZE with ratio N >= 2
ICAP_DATA_SIZE, 32, ICAP data width; must be a multiple of 8
FLAG_SIZE, 1, width of the fifo_empty, fifo_read_en and icap_en flags
LSW_FIRST, 1, 1 = bits [ICAP_DATA_SIZE-1:0] sent first; 0 = most-significant slice sent first
COUNT_WIDTH, 32, width of words_sent

Ports:
clock  in  1  single clock for all logic
reset  in  1  asynchronous, active-high reset
fifo_empty  in  FLAG_SIZE  1 = FIFO holds no word
fifo_data  in  DATA_SIZE  FIFO read data, valid the cycle after fifo_read_en
fifo_read_en  out  FLAG_SIZE  one-cycle pop strobe
icap_busy  in  1  1 = ICAP cannot accept a word this cycle
icap_data  out  ICAP_DATA_SIZE  current ICAP word
icap_en  out  FLAG_SIZE  1 = icap_data written this cycle
enable  in  1  permit starting new FIFO beats
abort  in  1  synchronous: drop the current beat and return to IDLE
clear_count  in  1  synchronous clear of words_sent
words_sent  out  COUNT_WIDTH  ICAP words written since the last reset or clear
state  out  2  IDLE=00, WAIT=01, SHIFT=10 (11 unused; decodes to IDLE)
idle  out  1  1 when state==IDLE

Behaviour:
- Reset values, applied asynchronously: state=IDLE, shift register=0, slice index=0, words_sent=0, fifo_read_en=0, icap_en=0, icap_data=0.
- IDLE:
  - fifo_read_en = enable & !fifo_empty & !abort (combinational).
  - When fifo_read_en is asserted, go to WAIT.
- WAIT:
  - Capture fifo_data into the shift register at the clock edge.
  - Clear the slice index and go to SHIFT.
  - If abort is high, go to IDLE instead and discard the data.
- SHIFT:
  - icap_data = slice[index]; the order follows LSW_FIRST.
  - icap_en = !icap_busy & !abort (combinational).
  - On icap_en, index increments and words_sent increments.
  - While icap_busy=1: icap_en=0, icap_data is held, index is unchanged. No timeout.
  - Last slice (index == N-1) accepted: if enable & !fifo_empty, assert fifo_read_en in the same cycle and go to WAIT; otherwise go to IDLE.
- Throughput with no back-pressure: N words per N+1 cycles. The single bubble is the WAIT cycle.
- abort has priority over every other transition:
  - Next state is IDLE; remaining slices are dropped.
  - No icap_en and no fifo_read_en in the abort cycle.
- Dropping enable mid-beat: the current beat completes, then the block goes to IDLE.
- words_sent:
  - Wraps modulo 2^COUNT_WIDTH.
  - If clear_count and an icap_en occur in the same cycle, the result is 1.
- icap_data outside SHIFT holds its last value. It is don't-care to the ICAP because icap_en=0.
- fifo_read_en is never asserted while fifo_empty=1.
- Reset mid-beat: immediate return to the reset values. A word popped but not yet sent is lost.

Optional Feature:
- Macro: ICAP_BITSWAP_EN.
- When defined: every byte of icap_data is bit-reversed (bit 0 <-> bit 7 within each byte) to match Xilinx ICAP bit ordering. Byte positions are unchanged.
- When undefined: icap_data is the raw slice.
- Control, timing and counting are identical in both builds.

Test Plan:
- Basic beat:
  - Stimulus: LSW_FIRST=1, no bitswap, enable=1, FIFO holds one word 256'hffff0008ffff0007ffff0006ffff0005ffff0004ffff0003ffff0002ffff0001.
  - Required: one fifo_read_en pulse, one WAIT cycle, then 8 consecutive icap_en cycles with icap_data = ffff0001, ffff0002, ... ffff0008; then IDLE; words_sent=8.
- Word order:
  - Stimulus: same word with LSW_FIRST=0.
  - Required: sequence ffff0008 down to ffff0001.
- Back-pressure:
  - Stimulus: icap_busy=1 for 3 cycles starting at the 3rd slice.
  - Required: icap_en=0 and icap_data held at ffff0003 during those cycles; all 8 words delivered in order; words_sent=8.
- Back-to-back:
  - Stimulus: two words queued (second 256'hffff0000...ffff0011).
  - Required: fifo_read_en in cycle 0 and again in cycle 9 (last slice of beat 1); beat 2 icap_en in cycles 11-18, first word ffff0011; words_sent=16.
- Abort and reset:
  - abort asserted at slice 4: no icap_en that cycle; IDLE next cycle; words_sent=4.
  - Separately, reset pulsed at slice 5: all outputs return to their reset values immediately.
- Bitswap (ICAP_BITSWAP_EN defined):
  - Stimulus: basic beat.
  - Required: first icap_data = ffff0080, second = ffff0040.
